// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divide/remainder unit for RV32M DIV/DIVU/REM/REMU.
// Signed operations run on magnitudes; the sign is applied when the result is latched.
module seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [4:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  kill_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_q, neg_d;

  logic                  op_ok, signed_op, rem_op, a_neg, b_neg, borrow;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, rem_step, quot_step, sel, final_res;
  logic [DATA_WIDTH:0]   shifted, diff;

  assign op_ok     = (op_i[4:2] == 3'b101);
  assign signed_op = ~op_i[0];
  assign rem_op    = op_i[1];
  assign a_neg     = signed_op & a_i[DATA_WIDTH-1];
  assign b_neg     = signed_op & b_i[DATA_WIDTH-1];
  assign a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag     = b_neg ? (~b_i + 1'b1) : b_i;

  // Borrow lands in the extra top bit because the shifted remainder is always < 2*divisor.
  assign shifted   = {rem_q, quot_q[DATA_WIDTH-1]};
  assign diff      = shifted - {1'b0, dvsr_q};
  assign borrow    = diff[DATA_WIDTH];
  assign rem_step  = borrow ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  assign quot_step = {quot_q[DATA_WIDTH-2:0], ~borrow};
  assign sel       = is_rem_q ? rem_step : quot_step;
  assign final_res = neg_q ? (~sel + 1'b1) : sel;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    res_d    = res_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i && !kill_i && op_ok) begin
          is_rem_d = rem_op;
          if (b_i == '0) begin
            res_d   = rem_op ? a_i : '1;
            state_d = S_DONE;
          end else if (signed_op && a_i == MOST_NEG && b_i == '1) begin
            res_d   = rem_op ? '0 : MOST_NEG;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quot_d  = a_mag;
            dvsr_d  = b_mag;
            neg_d   = rem_op ? a_neg : (a_neg ^ b_neg);
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = S_DONE;
            res_d   = final_res;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      res_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      res_q    <= res_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
    end
  end

  assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy_o  = (state_q == S_CALC);
  assign valid_o = (state_q == S_DONE);
  assign res_o   = res_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider against an arithmetic RV32M reference.
module tb_seq_divider;

  localparam logic [4:0] OP_DIV  = 5'b10100;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b10110;
  localparam logic [4:0] OP_REMU = 5'b10111;

  logic        clk = 1'b0;
  logic        rst, start_i, kill_i;
  logic [4:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] res_o;

  int vectors = 0;
  int miscompares = 0;

  seq_divider #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .kill_i(kill_i), .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .res_o(res_o)
  );

  always #5 clk = ~clk;

  // RV32M semantics straight from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIVU: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: ref_result = (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0)                                     ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
        else                                            ref_result = sa / sb;
      end
      default: begin
        if (b == 0)                                     ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h0;
        else                                            ref_result = sa % sb;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Waits for valid_o; lat counts edges since (and including) the acceptance edge.
  task automatic wait_result(input int lat0, output int lat, output int busy_n);
    lat = lat0;
    busy_n = 0;
    while (!valid_o && lat < 60) begin
      if (busy_o) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, busy_n, exp_lat;
    exp_lat = ref_latency(op, a, b);
    start_op(op, a, b);
    wait_result(1, lat, busy_n);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_res"}, res_o, ref_result(op, a, b));
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_n, exp_lat - 1);
    $display("op=%b a=%h b=%h res=%h lat=%0d busy=%0d", op, a, b, res_o, lat, busy_n);
  endtask

  initial begin
    int lat, busy_n, pulses;
    logic [4:0] rop;
    logic [31:0] ra, rb;

    rst = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_res", res_o, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
    check("divu_fixed", ref_result(OP_DIVU, 32'd100, 32'd7), 32'd14);
    run_op("div_m20_3", OP_DIV, 32'hFFFF_FFEC, 32'd3);
    run_op("rem_m20_3", OP_REM, 32'hFFFF_FFEC, 32'd3);
    run_op("div_20_m3", OP_DIV, 32'd20, 32'hFFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0);
    run_op("rem_by0", OP_REM, 32'hFFFF_FFEC, 32'd0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);

    // start during CALC is ignored
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_result(12, lat, busy_n);
    check("ign_valid", 32'(valid_o), 32'd1);
    check("ign_res", res_o, 32'd14);
    check("ign_lat", lat, 33);
    $display("ignored-start res=%h lat=%0d", res_o, lat);

    // kill in CALC
    start_op(OP_DIVU, 32'd200, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check("kill_ready", 32'(ready_o), 32'd1);
    check("kill_busy", 32'(busy_o), 32'd0);
    check("kill_valid", 32'(valid_o), 32'd0);
    check("kill_res", res_o, 32'd14);
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) pulses++; end
    check("kill_no_pulse", pulses, 0);
    $display("kill-in-calc res=%h pulses=%0d", res_o, pulses);

    // back-to-back issue from DONE
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_result(1, lat, busy_n);
    check("b2b_first", res_o, 32'd14);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("b2b_busy", 32'(busy_o), 32'd1);
    wait_result(1, lat, busy_n);
    check("b2b_res", res_o, 32'd3);
    check("b2b_lat", lat, 33);
    $display("back-to-back res=%h lat=%0d", res_o, lat);
    @(posedge clk); #1;

    // non-divide opcode is ignored
    start_i = 1'b1; op_i = 5'b00000; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("badop_busy", 32'(busy_o), 32'd0);
    check("badop_valid", 32'(valid_o), 32'd0);
    $display("bad-op busy=%b valid=%b", busy_o, valid_o);

    // kill with start in IDLE
    start_i = 1'b1; kill_i = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd0;
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("idlekill_valid", 32'(valid_o), 32'd0);
    check("idlekill_busy", 32'(busy_o), 32'd0);
    $display("idle-kill busy=%b valid=%b", busy_o, valid_o);

    // kill in DONE: pulse still visible, simultaneous start dropped
    start_op(OP_DIVU, 32'd5, 32'd0);
    check("donekill_pulse", 32'(valid_o), 32'd1);
    start_i = 1'b1; kill_i = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("donekill_ready", 32'(ready_o), 32'd1);
    check("donekill_busy", 32'(busy_o), 32'd0);
    check("donekill_valid", 32'(valid_o), 32'd0);
    $display("done-kill ready=%b busy=%b valid=%b", ready_o, busy_o, valid_o);

    for (int i = 0; i < 40; i++) begin
      rop = OP_DIV + 5'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // reset mid-CALC
    start_op(OP_DIVU, 32'd1000, 32'd7);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_res", res_o, 32'd0);
    $display("mid-calc reset res=%h ready=%b", res_o, ready_o);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
